// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per clock, with a valid/ready handshake on both sides.
module alu_muldiv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] ALUop1,
    input  logic [DATA_WIDTH-1:0] ALUop2,
    input  logic [2:0]            MDctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] MDout,
    output logic                  busy
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [2:0]         op;
    logic               neg_res;
    logic               neg_rem;
    logic [W-1:0]       opnd;
    logic [2*W-1:0]     acc;
    logic [CNT_WIDTH-1:0] count;

    logic               sgn1, sgn2, neg1, neg2;
    logic [W-1:0]       mag1, mag2;
    logic               div_zero, div_ovf;
    logic [W-1:0]       special_res;

    logic [W:0]         mul_sum, div_tmp, div_diff;
    logic               div_ge;
    logic [2*W-1:0]     step, prod;
    logic [W-1:0]       quo, rem, result;

    function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic n);
        return n ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*W-1:0] neg_if_wide(input logic [2*W-1:0] x, input logic n);
        return n ? (~x + 1'b1) : x;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Operand decode at acceptance: signedness, magnitudes and special cases.
    always_comb begin
        sgn1     = MDctrl[2] ? ~MDctrl[0] : (MDctrl[1:0] != 2'b11);
        sgn2     = MDctrl[2] ? ~MDctrl[0] : ~MDctrl[1];
        neg1     = sgn1 & ALUop1[W-1];
        neg2     = sgn2 & ALUop2[W-1];
        mag1     = neg_if(ALUop1, neg1);
        mag2     = neg_if(ALUop2, neg2);
        div_zero = MDctrl[2] && (ALUop2 == '0);
        div_ovf  = MDctrl[2] && !MDctrl[0] && (ALUop1 == {1'b1, {(W-1){1'b0}}}) && (ALUop2 == '1);
        if (div_zero)
            special_res = MDctrl[1] ? ALUop1 : '1;
        else
            special_res = MDctrl[1] ? '0 : ALUop1;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        div_tmp  = acc[2*W-1:W-1];
        div_diff = div_tmp - {1'b0, opnd};
        div_ge   = (div_tmp >= {1'b0, opnd});
        if (op[2])
            step = {(div_ge ? div_diff[W-1:0] : div_tmp[W-1:0]), acc[W-2:0], div_ge};
        else
            step = {mul_sum, acc[W-1:1]};
        prod = neg_if_wide(step, neg_res);
        quo  = neg_if(step[W-1:0], neg_res);
        rem  = neg_if(step[2*W-1:W], neg_rem);
        case (op)
            3'b000:                 result = prod[W-1:0];
            3'b001, 3'b010, 3'b011: result = prod[2*W-1:W];
            3'b100, 3'b101:         result = quo;
            default:                result = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            op      <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            count   <= '0;
            MDout   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op      <= MDctrl;
                        neg_res <= neg1 ^ neg2;
                        neg_rem <= neg1;
                        opnd    <= MDctrl[2] ? mag2 : mag1;
                        acc     <= {{W{1'b0}}, (MDctrl[2] ? mag1 : mag2)};
                        count   <= '0;
                        if (div_zero || div_ovf) begin
                            MDout <= special_res;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= step;
                    count <= count + 1'b1;
                    if (count == CNT_WIDTH'(W - 1)) begin
                        MDout <= result;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: arithmetic model of RV32M results plus
// literal expectations, a per-cycle output checker, latency and handshake checks.
module tb_alu_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] ALUop1, ALUop2, MDout;
    logic [2:0]  MDctrl;

    int          total = 0;
    int          bad   = 0;
    logic        pending = 1'b0;
    logic [31:0] exp_md  = '0;

    alu_muldiv_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .MDctrl(MDctrl),
        .out_valid(out_valid), .out_ready(out_ready), .MDout(MDout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: return a * b;
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Output checker: whenever out_valid is high it must carry the expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!pending)
                check("spurious_out_valid", 32'd1, 32'd0);
            else
                check("mdout", MDout, exp_md);
        end
    end

    task automatic scramble();
        ALUop1 = $urandom;
        ALUop2 = $urandom;
        MDctrl = 3'($urandom);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input bit use_lit,
                          input int hold);
        int lat;
        @(negedge clk);
        MDctrl = op; ALUop1 = a; ALUop2 = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        check({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        if (use_lit) check({name, "_model"}, model(op, a, b), lit);
        exp_md  = model(op, a, b);
        pending = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
            in_valid = 1'($urandom);
            scramble();
        end while (!out_valid && lat < 100);
        in_valid = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            scramble();
            check({name, "_bp_in_ready"}, 32'(in_ready), 32'd0);
            check({name, "_bp_out_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        pending = 1'b0;
        @(negedge clk);
        check({name, "_release_valid"}, 32'(out_valid), 32'd0);
        check({name, "_release_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ALUop1 = '0; ALUop2 = '0; MDctrl = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mdout", MDout, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        run_op("mul_7_m3",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0);
        run_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0);
        run_op("mulh_ff",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
        run_op("mulhsu_ff",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        run_op("mul_ff",     3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1, 0);
        run_op("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1, 0);
        run_op("div_m20_6",  3'd4, 32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 1, 0);
        run_op("rem_m20_6",  3'd6, 32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 1, 0);
        run_op("divu_20_6",  3'd5, 32'd20,         32'd6,         32'd3,         1, 0);
        run_op("remu_20_6",  3'd7, 32'd20,         32'd6,         32'd2,         1, 0);
        run_op("div_7_m2",   3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 0);
        run_op("rem_7_m2",   3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         1, 0);
        run_op("divu_max_1", 3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1, 0);
        run_op("divu_5_0",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("div_5_0",    3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("rem_5_0",    3'd6, 32'd5,          32'd0,         32'd5,         1, 0);
        run_op("remu_5_0",   3'd7, 32'd5,          32'd0,         32'd5,         1, 0);
        run_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0);
        run_op("bp_mul",     3'd0, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FD44, 1, 5);
        run_op("bp_special", 3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, 1, 3);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            run_op("rand", 3'(i % 8), a, b, 32'd0, 0, 0);
        end

        // Abort a divide mid-flight with reset; its result must never appear.
        @(negedge clk);
        MDctrl = 3'd4; ALUop1 = 32'd100; ALUop2 = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_mdout", MDout, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy_low", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
